// File: rtl/fetch_if.sv
// fetch_if: control inputs, instruction-memory port and IF/ID outputs of the fetch stage
interface fetch_if #(
    parameter int INST_LENGTH = 32,
    parameter int ADDR_LENGTH = 32
);
    logic                   PCSel;
    logic [ADDR_LENGTH-1:0] alu_target;
    logic                   stall;
    logic                   imem_req;
    logic [ADDR_LENGTH-1:0] imem_addr;
    logic [INST_LENGTH-1:0] imem_rdata;
    logic                   imem_ready;
    logic [INST_LENGTH-1:0] id_inst;
    logic [ADDR_LENGTH-1:0] id_pc;
    logic [ADDR_LENGTH-1:0] id_pc4;
    logic                   id_valid;
    modport master (
        input  PCSel, alu_target, stall, imem_rdata, imem_ready,
        output imem_req, imem_addr, id_inst, id_pc, id_pc4, id_valid
    );
    modport slave (
        output PCSel, alu_target, stall, imem_rdata, imem_ready,
        input  imem_req, imem_addr, id_inst, id_pc, id_pc4, id_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, request/ready instruction fetch and IF/ID pipeline register
module fetch_stage #(
    parameter int INST_LENGTH = 32,
    parameter int ADDR_LENGTH = 32,
    parameter logic [ADDR_LENGTH-1:0] RESET_PC = 32'h00000000,
    parameter logic [INST_LENGTH-1:0] NOP_INST = 32'h00000013
) (
    input  logic clk,
    input  logic rst,
    fetch_if.master bus
);
    typedef enum logic [1:0] {BOOT, FETCH, HELD, DRAIN} state_t;
    state_t                 state_q, state_d;
    logic [ADDR_LENGTH-1:0] pc_q, pc_d, redirect_pc_q, redirect_pc_d;
    logic [ADDR_LENGTH-1:0] id_pc_q, id_pc_d, id_pc4_q, id_pc4_d;
    logic [INST_LENGTH-1:0] id_inst_q, id_inst_d, skid_q, skid_d;
    logic                   id_valid_q, id_valid_d, outstanding_q, outstanding_d;
    logic [ADDR_LENGTH-1:0] target, pc4;
    logic                   req, done;

    assign target        = bus.alu_target & ~ADDR_LENGTH'(3);
    assign pc4           = pc_q + ADDR_LENGTH'(4);
    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.id_inst   = id_inst_q;
    assign bus.id_pc     = id_pc_q;
    assign bus.id_pc4    = id_pc4_q;
    assign bus.id_valid  = id_valid_q;

    // next-state: redirect beats completion beats stall; DRAIN keeps the old address until the memory lets go
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redirect_pc_d = redirect_pc_q;
        skid_d        = skid_q;
        id_inst_d     = id_inst_q;
        id_pc_d       = id_pc_q;
        id_pc4_d      = id_pc4_q;
        id_valid_d    = id_valid_q;
        req           = (state_q == DRAIN) || (state_q == FETCH && (!bus.stall || outstanding_q));
        done          = req && bus.imem_ready;
        outstanding_d = req && !bus.imem_ready;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
                if (bus.PCSel) pc_d = target;
            end
            FETCH: begin
                if (bus.PCSel) begin
                    id_inst_d  = NOP_INST;
                    id_valid_d = 1'b0;
                    if (outstanding_q && !bus.imem_ready) begin
                        redirect_pc_d = target;
                        state_d       = DRAIN;
                    end else begin
                        pc_d = target;
                    end
                end else if (done && !bus.stall) begin
                    id_inst_d  = bus.imem_rdata;
                    id_pc_d    = pc_q;
                    id_pc4_d   = pc4;
                    id_valid_d = 1'b1;
                    pc_d       = pc4;
                end else if (done) begin
                    skid_d  = bus.imem_rdata;
                    state_d = HELD;
                end else if (!bus.stall) begin
                    id_inst_d  = NOP_INST;
                    id_valid_d = 1'b0;
                end
            end
            HELD: begin
                if (bus.PCSel) begin
                    pc_d       = target;
                    skid_d     = NOP_INST;
                    id_inst_d  = NOP_INST;
                    id_valid_d = 1'b0;
                    state_d    = FETCH;
                end else if (!bus.stall) begin
                    id_inst_d  = skid_q;
                    id_pc_d    = pc_q;
                    id_pc4_d   = pc4;
                    id_valid_d = 1'b1;
                    pc_d       = pc4;
                    state_d    = FETCH;
                end
            end
            DRAIN: begin
                if (bus.PCSel) redirect_pc_d = target;
                if (bus.imem_ready) begin
                    pc_d    = redirect_pc_d;
                    state_d = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // state and pipeline registers; reset abandons any in-flight request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            redirect_pc_q <= RESET_PC;
            skid_q        <= NOP_INST;
            id_inst_q     <= NOP_INST;
            id_pc_q       <= '0;
            id_pc4_q      <= '0;
            id_valid_q    <= 1'b0;
            outstanding_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redirect_pc_q <= redirect_pc_d;
            skid_q        <= skid_d;
            id_inst_q     <= id_inst_d;
            id_pc_q       <= id_pc_d;
            id_pc4_q      <= id_pc4_d;
            id_valid_q    <= id_valid_d;
            outstanding_q <= outstanding_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, reset/wrap sequences and random run against a reference model
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h00000013;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    fetch_if bus ();
    fetch_stage dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    assign bus.imem_rdata = bus.imem_addr | 32'h13;

    typedef struct {
        logic s, p, r;
        logic [31:0] t;
        logic req;
        logic [31:0] addr, inst, pc;
        logic v;
    } vec_t;

    logic m_boot, m_held, m_drain, m_out, m_valid;
    logic [31:0] m_pc, m_redir, m_skid, m_inst, m_idpc, m_idpc4;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    task automatic model_reset();
        m_boot = 1; m_held = 0; m_drain = 0; m_out = 0; m_valid = 0;
        m_pc = 0; m_redir = 0; m_skid = NOP; m_inst = NOP; m_idpc = 0; m_idpc4 = 0;
    endtask

    function automatic logic m_req(input logic s);
        return !m_boot && !m_held && (m_drain || !s || m_out);
    endfunction

    task automatic accept(input logic [31:0] x);
        m_inst = x; m_idpc = m_pc; m_idpc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
    endtask

    task automatic flush();
        m_inst = NOP; m_valid = 0;
    endtask

    task automatic model_step(input logic s, input logic p, input logic r, input logic [31:0] t);
        logic q;
        logic [31:0] tg;
        q  = m_req(s);
        tg = t & ~32'h3;
        if (m_boot) begin
            m_boot = 0;
            if (p) m_pc = tg;
        end else if (m_drain) begin
            if (p) m_redir = tg;
            if (r) begin m_drain = 0; m_pc = m_redir; end
        end else if (m_held) begin
            if (p) begin m_pc = tg; flush(); m_held = 0; end
            else if (!s) begin accept(m_skid); m_held = 0; end
        end else if (p) begin
            flush();
            if (m_out && !r) begin m_redir = tg; m_drain = 1; end
            else m_pc = tg;
        end else if (q && r) begin
            if (s) begin m_skid = m_pc | 32'h13; m_held = 1; end
            else accept(m_pc | 32'h13);
        end else if (!s) flush();
        m_out = q && !r;
    endtask

    task automatic do_reset();
        rst = 1;
        bus.stall = 0; bus.PCSel = 0; bus.imem_ready = 0; bus.alu_target = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_reset();
    endtask

    task automatic cycle(input logic s, input logic p, input logic r, input logic [31:0] t,
                         input bit cmp, output logic gr, output logic [31:0] ga);
        bus.stall = s; bus.PCSel = p; bus.imem_ready = r; bus.alu_target = t;
        @(negedge clk);
        gr = bus.imem_req;
        ga = bus.imem_addr;
        if (cmp) begin
            chk("imem_req", 32'(gr), 32'(m_req(s)));
            chk("imem_addr", ga, m_pc);
        end
        model_step(s, p, r, t);
        @(posedge clk);
        #1;
        if (cmp) begin
            chk("id_inst", bus.id_inst, m_inst);
            chk("id_pc", bus.id_pc, m_idpc);
            chk("id_pc4", bus.id_pc4, m_idpc4);
            chk("id_valid", 32'(bus.id_valid), 32'(m_valid));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[22];
        logic gr;
        logic [31:0] ga;
        vt[0]  = '{0,0,1,32'h0,   0,32'h0,   NOP,        32'h0,  0};
        vt[1]  = '{0,0,1,32'h0,   1,32'h0,   32'h13,     32'h0,  1};
        vt[2]  = '{0,0,1,32'h0,   1,32'h4,   32'h17,     32'h4,  1};
        vt[3]  = '{0,0,0,32'h0,   1,32'h8,   NOP,        32'h4,  0};
        vt[4]  = '{0,0,0,32'h0,   1,32'h8,   NOP,        32'h4,  0};
        vt[5]  = '{0,0,0,32'h0,   1,32'h8,   NOP,        32'h4,  0};
        vt[6]  = '{0,0,1,32'h0,   1,32'h8,   32'h1B,     32'h8,  1};
        vt[7]  = '{0,0,0,32'h0,   1,32'hC,   NOP,        32'h8,  0};
        vt[8]  = '{1,0,1,32'h0,   1,32'hC,   NOP,        32'h8,  0};
        vt[9]  = '{1,0,1,32'h0,   0,32'hC,   NOP,        32'h8,  0};
        vt[10] = '{0,0,1,32'h0,   0,32'hC,   32'h1F,     32'hC,  1};
        vt[11] = '{0,1,1,32'h103, 1,32'h10,  NOP,        32'hC,  0};
        vt[12] = '{0,0,1,32'h0,   1,32'h100, 32'h113,    32'h100,1};
        vt[13] = '{0,1,1,32'h10,  1,32'h104, NOP,        32'h100,0};
        vt[14] = '{0,0,0,32'h0,   1,32'h10,  NOP,        32'h100,0};
        vt[15] = '{0,1,0,32'h40,  1,32'h10,  NOP,        32'h100,0};
        vt[16] = '{0,0,0,32'h0,   1,32'h10,  NOP,        32'h100,0};
        vt[17] = '{0,0,1,32'h0,   1,32'h10,  NOP,        32'h100,0};
        vt[18] = '{0,0,1,32'h0,   1,32'h40,  32'h53,     32'h40, 1};
        vt[19] = '{1,0,1,32'h0,   0,32'h44,  32'h53,     32'h40, 1};
        vt[20] = '{1,1,1,32'h80,  0,32'h44,  NOP,        32'h40, 0};
        vt[21] = '{0,0,1,32'h0,   1,32'h80,  32'h93,     32'h80, 1};

        do_reset();
        chk("rst_id_valid", 32'(bus.id_valid), 0);
        chk("rst_id_inst", bus.id_inst, NOP);
        for (int i = 0; i < 22; i++) begin
            cycle(vt[i].s, vt[i].p, vt[i].r, vt[i].t, 0, gr, ga);
            chk($sformatf("vec%0d_req", i), 32'(gr), 32'(vt[i].req));
            chk($sformatf("vec%0d_addr", i), ga, vt[i].addr);
            chk($sformatf("vec%0d_inst", i), bus.id_inst, vt[i].inst);
            chk($sformatf("vec%0d_pc", i), bus.id_pc, vt[i].pc);
            chk($sformatf("vec%0d_valid", i), 32'(bus.id_valid), 32'(vt[i].v));
            if (vt[i].v) chk($sformatf("vec%0d_pc4", i), bus.id_pc4, vt[i].pc + 4);
        end

        do_reset();
        cycle(0, 0, 1, 0, 1, gr, ga);
        cycle(0, 0, 0, 0, 1, gr, ga);
        cycle(0, 1, 0, 32'h40, 1, gr, ga);
        bus.stall = 0; bus.PCSel = 0; bus.imem_ready = 0;
        @(negedge clk);
        chk("drain_req", 32'(bus.imem_req), 1);
        rst = 1;
        #1;
        chk("async_rst_req", 32'(bus.imem_req), 0);
        chk("async_rst_addr", bus.imem_addr, 32'h0);
        chk("async_rst_inst", bus.id_inst, NOP);
        chk("async_rst_pc", bus.id_pc, 32'h0);
        chk("async_rst_pc4", bus.id_pc4, 32'h0);
        chk("async_rst_valid", 32'(bus.id_valid), 0);
        @(posedge clk);
        #1 rst = 0;
        model_reset();
        cycle(0, 0, 1, 0, 1, gr, ga);
        cycle(0, 0, 1, 0, 1, gr, ga);
        chk("post_rst_first_addr", ga, 32'h0);
        cycle(0, 1, 1, 32'hFFFFFFFF, 1, gr, ga);
        cycle(0, 0, 1, 0, 1, gr, ga);
        chk("wrap_id_pc", bus.id_pc, 32'hFFFFFFFC);
        chk("wrap_id_pc4", bus.id_pc4, 32'h0);
        cycle(0, 0, 1, 0, 1, gr, ga);
        chk("wrap_next_addr", ga, 32'h0);

        do_reset();
        for (int i = 0; i < 800; i++)
            cycle($urandom_range(2, 0) == 0, $urandom_range(5, 0) == 0, $urandom_range(2, 0) != 0,
                  $urandom, 1, gr, ga);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
